spi_loopback: RTL and testbench
===============================

# spi_loopback

Self-checking SPI loopback block: one SPI master and one SPI slave, wired together internally through SCLK, MOSI, MISO and CS_n. Both run on a single system clock. A start pulse transfers `data_master_in` to the slave and `data_slave_in` to the master in one full-duplex frame. It is used to bring up and regress the SPI master and slave cores before they are split across chips.

## Interface
- `system_clk_frequency`, default 50_000_000: system clock frequency in Hz.
- `spi_clk_frequency`, default 5_000_000: SCLK frequency in Hz.
- `data_width`, default 8: bits per frame.
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_master_in`  in  data_width  word the master transmits; latched at start.
- `data_slave_in`  in  data_width  word the slave transmits; latched when the slave detects CS_n falling.
- `start_master`  in  1  one-cycle start request.
- `finish_master`  out  1  one-cycle pulse at the end of the master frame.
- `data_master_out`  out  data_width  word received by the master; holds until the next frame.
- `data_slave_out`  out  data_width  word received by the slave; holds until the next frame.
- `data_valid_slave`  out  1  one-cycle pulse when `data_slave_out` is updated.

## Operation
- HALF = system_clk_frequency / (2*spi_clk_frequency), computed at elaboration. Integer division; HALF ≥ 4 is required, and a smaller value is an elaboration error.
- Frames are MSB first.
- Master FSM has four states: IDLE → LEAD → XFER → TRAIL → IDLE.
  - IDLE: `start_master` high → latch `data_master_in`, drive CS_n low, drive MOSI = MSB when CPHA=0, go to LEAD.
  - LEAD: wait HALF cycles, then go to XFER.
  - XFER: toggle SCLK every HALF cycles, 2*data_width toggles in total.
    - On each sample edge, shift MISO into the receive register.
    - On each shift edge, drive the next MOSI bit. With CPHA=1 the first bit is driven on the first edge.
  - TRAIL: wait HALF cycles, then drive CS_n high, load `data_master_out`, pulse `finish_master`, and return to IDLE.
- `start_master` outside IDLE is ignored.
- Slave:
  - SCLK, CS_n and MOSI pass through 2-FF synchronizers, followed by edge detection.
  - On the CS_n falling edge, load `data_slave_in` and present its MSB on MISO when CPHA=0.
  - On each sync'd sample edge, shift MOSI in. On each shift edge, advance MISO.
  - After the data_width-th sample, load `data_slave_out` and pulse `data_valid_slave`.
  - A CS_n rising edge resets the bit counter.
- Reset values:
  - `finish_master`, `data_valid_slave`: 0.
  - `data_master_out`, `data_slave_out`: 0.
  - SCLK = CPOL, CS_n = 1, MOSI = MISO = 0.
  - Both FSMs go to IDLE.
- Reset mid-frame aborts immediately. No valid or finish pulse is issued, and the outputs return to their reset values.

## Timing
- `start_master` is sampled at cycle 0. CS_n falls at cycle 1.
- The first SCLK edge is at cycle 1+HALF. The last edge is at cycle 1+2*data_width*HALF.
- CS_n rises and `finish_master` is high at cycle 1+(2*data_width+1)*HALF. With the defaults this is cycle 86.
- `data_master_out` holds its new value from the cycle after `finish_master` is asserted.
- `data_valid_slave` rises 3 clk after the final sample edge. This is at least HALF−3 cycles before `finish_master`, so a consumer may still compare against the current `data_master_in`.
- Back-to-back frames: a new `start_master` is accepted in the cycle after `finish_master`. CS_n stays high for at least 1 cycle.
- Slave MISO is valid at most 3 cycles after the CS_n fall or shift edge, which is before the master samples it (HALF ≥ 4).

## Structure
- Shared package `spi_pkg`:
  - Master FSM state enum.
  - HALF computation function.
  - Sample-edge and shift-edge selection from CPOL/CPHA.
- Sub-modules: `spi_master` (clock divider, FSM, shift register) and `spi_slave` (synchronizers, edge detect, shift registers).
- The top level only instantiates and wires the two.

## Test plan
- Mode 0, defaults; master 0xA5, slave 0x3C, one start → `data_slave_out`=0xA5, `data_master_out`=0x3C, `data_valid_slave` 1-cycle pulse before the 1-cycle `finish_master`.
- Back-to-back frames: master 0xA5 then 0x9A (changed on `finish_master`), restart after `finish_master` falls → second frame gives slave 0x9A with no corruption of the first.
- Start pulses during XFER → ignored; exactly one `finish_master` pulse.
- Modes 1, 2, 3 with 0x81/0x7E, plus all-0x00 and all-0xFF → both directions match; SCLK idle = CPOL.
- `rst_n` low mid-frame (bit 4) → outputs 0, CS_n=1, no pulses; the next frame transfers correctly.
- data_width=16, spi_clk_frequency=2.5 MHz (HALF=10): 0xBEEF/0x1234 → both match; `finish_master` at cycle 331.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI loopback master/slave pair.
package spi_pkg;

    // Master frame sequencing states.
    typedef enum logic [1:0] {
        M_IDLE,
        M_LEAD,
        M_XFER,
        M_TRAIL
    } master_state_e;

    // System clocks per SCLK half period (integer division).
    function automatic int calc_half(input int sys_hz, input int spi_hz);
        return sys_hz / (2 * spi_hz);
    endfunction

    // Data is sampled on the leading edge for CPHA=0 and on the trailing
    // edge for CPHA=1; the leading edge is rising when CPOL=0. The
    // combination collapses to "sample on rising edge when CPOL==CPHA".
    // The shift edge is always the opposite one.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return logic'(cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master: SCLK divider, frame FSM and MSB-first shift registers.
module spi_master
    import spi_pkg::*;
#(
    parameter int SYS_HZ = 50_000_000,
    parameter int SPI_HZ = 5_000_000,
    parameter int W      = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] data_i,
    input  logic         miso_i,
    output logic         sclk_o,
    output logic         cs_n_o,
    output logic         mosi_o,
    output logic         finish_o,
    output logic [W-1:0] data_o
);

    localparam int   HALF        = calc_half(SYS_HZ, SPI_HZ);
    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam int   CNT_W       = $clog2(HALF + 1);
    localparam int   EDGE_W      = $clog2(2 * W + 1);
    localparam logic IDLE_SCLK   = logic'(CPOL != 0);

    // The slave needs up to 3 cycles to react to an edge; fewer system
    // clocks per half period cannot be made to work.
    if (HALF < 4) begin : g_half_check
        $error("spi_master: system_clk_frequency/(2*spi_clk_frequency) must be >= 4");
    end

    master_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edges_q, edges_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              finish_q, finish_d;
    logic [W-1:0]      tx_q, tx_d;
    logic [W-1:0]      rx_q, rx_d;
    logic [W-1:0]      dout_q, dout_d;
    logic              tick;

    assign tick = (cnt_q == CNT_W'(HALF - 1));

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= M_IDLE;
            cnt_q    <= '0;
            edges_q  <= '0;
            sclk_q   <= IDLE_SCLK;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            finish_q <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edges_q  <= edges_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
            finish_q <= finish_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
        end
    end

    // Next-state logic: LEAD and XFER share the toggle path, the lead-in
    // ending with the first SCLK edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edges_d  = edges_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        finish_d = 1'b0;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        unique case (state_q)
            M_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    // For CPHA=0 the MSB goes out now, so preload the shifter
                    // with the remaining bits; CPHA=1 drives MSB on edge 1.
                    tx_d    = (CPHA == 0) ? (data_i << 1) : data_i;
                    mosi_d  = (CPHA == 0) ? data_i[W-1] : 1'b0;
                    cs_n_d  = 1'b0;
                    edges_d = '0;
                    state_d = M_LEAD;
                end
            end
            M_LEAD, M_XFER: begin
                if (tick) begin
                    cnt_d   = '0;
                    sclk_d  = ~sclk_q;
                    edges_d = edges_q + EDGE_W'(1);
                    if ((~sclk_q) == SAMPLE_RISE) begin
                        rx_d = {rx_q[W-2:0], miso_i};
                    end else begin
                        mosi_d = tx_q[W-1];
                        tx_d   = tx_q << 1;
                    end
                    state_d = (edges_q == EDGE_W'(2 * W - 1)) ? M_TRAIL : M_XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            M_TRAIL: begin
                if (tick) begin
                    cnt_d    = '0;
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
                    finish_d = 1'b1;
                    dout_d   = rx_q;
                    state_d  = M_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    assign sclk_o   = sclk_q;
    assign cs_n_o   = cs_n_q;
    assign mosi_o   = mosi_q;
    assign finish_o = finish_q;
    assign data_o   = dout_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: 2-FF synchronizers, edge detection and MSB-first shifters.
module spi_slave
    import spi_pkg::*;
#(
    parameter int W    = 8,
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk_i,
    input  logic         cs_n_i,
    input  logic         mosi_i,
    input  logic [W-1:0] data_i,
    output logic         miso_o,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam int   BIT_W       = $clog2(W + 1);
    localparam logic IDLE_SCLK   = logic'(CPOL != 0);

    logic              sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic              cs_s1_q, cs_s2_q, cs_s3_q;
    logic              mosi_s1_q, mosi_s2_q;
    logic [W-1:0]      tx_q;
    logic [W-2:0]      rx_q;
    logic [BIT_W-1:0]  bitcnt_q;
    logic              miso_q;
    logic [W-1:0]      dout_q;
    logic              valid_q;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              sample_edge, shift_edge;
    logic [W-1:0]      rx_next;

    assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall   = ~sclk_s2_q & sclk_s3_q;
    assign cs_fall     = ~cs_s2_q & cs_s3_q;
    assign cs_rise     = cs_s2_q & ~cs_s3_q;
    assign sample_edge = ~cs_s2_q & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_edge  = ~cs_s2_q & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    assign rx_next     = {rx_q, mosi_s2_q};

    // Synchronizers; the third stage keeps the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q <= IDLE_SCLK;
            sclk_s2_q <= IDLE_SCLK;
            sclk_s3_q <= IDLE_SCLK;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= cs_n_i;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= mosi_i;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Frame datapath: load on select, shift/sample on synchronized edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q     <= '0;
            rx_q     <= '0;
            bitcnt_q <= '0;
            miso_q   <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (cs_fall) begin
                tx_q     <= (CPHA == 0) ? (data_i << 1) : data_i;
                miso_q   <= (CPHA == 0) ? data_i[W-1] : 1'b0;
                bitcnt_q <= '0;
            end else if (cs_rise) begin
                bitcnt_q <= '0;
            end else begin
                if (sample_edge) begin
                    rx_q <= rx_next[W-2:0];
                    if (bitcnt_q == BIT_W'(W - 1)) begin
                        dout_q   <= rx_next;
                        valid_q  <= 1'b1;
                        bitcnt_q <= '0;
                    end else begin
                        bitcnt_q <= bitcnt_q + BIT_W'(1);
                    end
                end
                if (shift_edge) begin
                    miso_q <= tx_q[W-1];
                    tx_q   <= tx_q << 1;
                end
            end
        end
    end

    assign miso_o  = miso_q;
    assign data_o  = dout_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/spi_loopback.sv
// SPI master and slave wired back to back on one system clock.
module spi_loopback
    import spi_pkg::*;
#(
    parameter int system_clk_frequency = 50_000_000,
    parameter int spi_clk_frequency    = 5_000_000,
    parameter int data_width           = 8,
    parameter int CPOL                 = 0,
    parameter int CPHA                 = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] data_master_in,
    input  logic [data_width-1:0] data_slave_in,
    input  logic                  start_master,
    output logic                  finish_master,
    output logic [data_width-1:0] data_master_out,
    output logic [data_width-1:0] data_slave_out,
    output logic                  data_valid_slave
);

    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    spi_master #(
        .SYS_HZ (system_clk_frequency),
        .SPI_HZ (spi_clk_frequency),
        .W      (data_width),
        .CPOL   (CPOL),
        .CPHA   (CPHA)
    ) u_master (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_master),
        .data_i   (data_master_in),
        .miso_i   (miso),
        .sclk_o   (sclk),
        .cs_n_o   (cs_n),
        .mosi_o   (mosi),
        .finish_o (finish_master),
        .data_o   (data_master_out)
    );

    spi_slave #(
        .W    (data_width),
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_slave (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk_i  (sclk),
        .cs_n_i  (cs_n),
        .mosi_i  (mosi),
        .data_i  (data_slave_in),
        .miso_o  (miso),
        .data_o  (data_slave_out),
        .valid_o (data_valid_slave)
    );

endmodule

// File: tb/tb_spi_loopback.sv
// Bench: four 8-bit instances (SPI modes 0..3) and one 16-bit instance.
module tb_spi_loopback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] dm_in [5];
    logic [15:0] ds_in [5];
    logic        start [5];
    wire  [15:0] dm_out [5];
    wire  [15:0] ds_out [5];
    wire         fin [5];
    wire         val [5];
    wire         sclk_w [5];
    wire         csn_w [5];

    int vectors = 0;
    int miscompares = 0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        wire [7:0] m_out;
        wire [7:0] s_out;
        spi_loopback #(
            .system_clk_frequency (50_000_000),
            .spi_clk_frequency    (5_000_000),
            .data_width           (8),
            .CPOL                 ((gi >> 1) & 1),
            .CPHA                 (gi & 1)
        ) dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .data_master_in   (dm_in[gi][7:0]),
            .data_slave_in    (ds_in[gi][7:0]),
            .start_master     (start[gi]),
            .finish_master    (fin[gi]),
            .data_master_out  (m_out),
            .data_slave_out   (s_out),
            .data_valid_slave (val[gi])
        );
        assign dm_out[gi] = {8'h00, m_out};
        assign ds_out[gi] = {8'h00, s_out};
        assign sclk_w[gi] = dut.sclk;
        assign csn_w[gi]  = dut.cs_n;
    end

    spi_loopback #(
        .system_clk_frequency (50_000_000),
        .spi_clk_frequency    (2_500_000),
        .data_width           (16),
        .CPOL                 (0),
        .CPHA                 (0)
    ) dut_wide (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_master_in   (dm_in[4]),
        .data_slave_in    (ds_in[4]),
        .start_master     (start[4]),
        .finish_master    (fin[4]),
        .data_master_out  (dm_out[4]),
        .data_slave_out   (ds_out[4]),
        .data_valid_slave (val[4])
    );
    assign sclk_w[4] = dut_wide.sclk;
    assign csn_w[4]  = dut_wide.cs_n;

    function automatic int width_of(input int m);
        return (m == 4) ? 16 : 8;
    endfunction

    function automatic int half_of(input int m);
        return (m == 4) ? 10 : 5;
    endfunction

    function automatic logic cpol_of(input int m);
        return (m == 2 || m == 3) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic cpha_of(input int m);
        return (m == 1 || m == 3) ? 1'b1 : 1'b0;
    endfunction

    // One full frame on instance m, checked against the exchange rule:
    // slave receives a, master receives b, with frame timing derived from
    // HALF and the width.
    task automatic run_frame(input int m, input logic [15:0] a, input logic [15:0] b,
                             input bit extra, input string tag);
        int          w;
        int          h;
        int          exp_fin;
        int          exp_val;
        int          fin_cyc;
        int          val_cyc;
        int          fin_cnt;
        int          val_cnt;
        int          late;
        logic [15:0] mask;
        logic [15:0] exp_s;
        logic [15:0] exp_m;
        w       = width_of(m);
        h       = half_of(m);
        mask    = (w == 16) ? 16'hFFFF : 16'h00FF;
        exp_s   = a & mask;
        exp_m   = b & mask;
        exp_fin = 1 + (2 * w + 1) * h;
        // Last sample edge: leading edge of the last bit (CPHA=0) or the
        // final trailing edge (CPHA=1); valid follows it by 3 clocks.
        exp_val = (cpha_of(m) ? 1 + 2 * w * h : 1 + (2 * w - 1) * h) + 3;
        fin_cyc = -1;
        val_cyc = -1;
        fin_cnt = 0;
        val_cnt = 0;
        late    = 0;

        @(posedge clk); #1;
        dm_in[m] = a;
        ds_in[m] = b;
        start[m] = 1'b1;
        @(posedge clk); #1;
        start[m] = 1'b0;

        vectors++;
        if (csn_w[m] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s m%0d cs_fall: cs_n=%b expected 0 at cycle 1", tag, m, csn_w[m]);
        end

        for (int c = 1; c <= exp_fin + 40 && fin_cnt == 0; c++) begin
            if (extra) start[m] = (c == exp_fin / 3 || c == exp_fin / 2 || c == (2 * exp_fin) / 3);
            if (val[m] === 1'b1) begin
                val_cnt++;
                if (val_cyc < 0) val_cyc = c;
            end
            if (fin[m] === 1'b1) begin
                fin_cnt++;
                fin_cyc = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        start[m] = 1'b0;

        vectors++;
        if (fin_cyc != exp_fin) begin
            miscompares++;
            $display("FAIL %s m%0d finish_cycle: got %0d expected %0d", tag, m, fin_cyc, exp_fin);
        end
        vectors++;
        if (val_cnt != 1 || val_cyc != exp_val) begin
            miscompares++;
            $display("FAIL %s m%0d valid_pulse: count %0d at cycle %0d expected 1 at cycle %0d",
                     tag, m, val_cnt, val_cyc, exp_val);
        end
        vectors++;
        if (ds_out[m] !== exp_s) begin
            miscompares++;
            $display("FAIL %s m%0d slave_data: got %h expected %h", tag, m, ds_out[m], exp_s);
        end
        vectors++;
        if (csn_w[m] !== 1'b1 || sclk_w[m] !== cpol_of(m)) begin
            miscompares++;
            $display("FAIL %s m%0d bus_idle: cs_n=%b sclk=%b expected cs_n=1 sclk=%b",
                     tag, m, csn_w[m], sclk_w[m], cpol_of(m));
        end

        @(posedge clk); #1;
        vectors++;
        if (dm_out[m] !== exp_m) begin
            miscompares++;
            $display("FAIL %s m%0d master_data: got %h expected %h", tag, m, dm_out[m], exp_m);
        end
        for (int k = 0; k < 3; k++) begin
            if (fin[m] !== 1'b0 || val[m] !== 1'b0) late++;
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        vectors++;
        if (late != 0) begin
            miscompares++;
            $display("FAIL %s m%0d pulse_width: %0d extra pulse cycles after finish expected 0",
                     tag, m, late);
        end
        $display("frame %s m%0d: master %h -> slave %h, slave %h -> master %h, finish@%0d",
                 tag, m, exp_s, ds_out[m], exp_m, dm_out[m], fin_cyc);
    endtask

    task automatic check_idle(input int m, input string tag);
        vectors++;
        if (dm_out[m] !== 16'h0 || ds_out[m] !== 16'h0 || fin[m] !== 1'b0 || val[m] !== 1'b0 ||
            csn_w[m] !== 1'b1 || sclk_w[m] !== cpol_of(m)) begin
            miscompares++;
            $display("FAIL %s m%0d reset_state: mo=%h so=%h fin=%b val=%b cs_n=%b sclk=%b expected 0 0 0 0 1 %b",
                     tag, m, dm_out[m], ds_out[m], fin[m], val[m], csn_w[m], sclk_w[m], cpol_of(m));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int m = 0; m < 5; m++) begin
            dm_in[m] = '0;
            ds_in[m] = '0;
            start[m] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 5; m++) check_idle(m, "reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_mode0();
        run_frame(0, 16'h00A5, 16'h003C, 1'b0, "mode0");
        for (int i = 0; i < 2; i++)
            run_frame(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0, "mode0_rand");
    endtask

    task automatic test_back_to_back();
        run_frame(0, 16'h00A5, 16'($urandom_range(0, 255)), 1'b0, "b2b_first");
        run_frame(0, 16'h009A, 16'($urandom_range(0, 255)), 1'b0, "b2b_second");
    endtask

    task automatic test_ignored_start();
        run_frame(0, 16'h0055, 16'h00C9, 1'b1, "ignored_start");
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            run_frame(m, 16'h0081, 16'h007E, 1'b0, "modes");
            run_frame(m, 16'h0000, 16'h0000, 1'b0, "modes_zero");
            run_frame(m, 16'h00FF, 16'h00FF, 1'b0, "modes_ones");
            run_frame(m, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0, "modes_rand");
        end
        run_frame(0, 16'h0000, 16'h00FF, 1'b0, "mode0_edges");
    endtask

    task automatic test_reset_mid();
        int pulses;
        run_frame(0, 16'h00C3, 16'h005A, 1'b0, "pre_reset");
        @(posedge clk); #1;
        dm_in[0] = 16'h0096;
        ds_in[0] = 16'h0069;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        // Roughly the middle of bit 4 of the frame.
        repeat (45) @(posedge clk);
        #1;
        vectors++;
        if (csn_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid m0 in_frame: cs_n=%b expected 0 before reset", csn_w[0]);
        end
        rst_n = 1'b0;
        #2;
        check_idle(0, "reset_mid_async");
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (fin[0] !== 1'b0 || val[0] !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_mid m0 no_pulse: %0d pulse cycles during reset expected 0", pulses);
        end
        check_idle(0, "reset_mid_held");
        rst_n = 1'b1;
        $display("reset mid-frame m0 applied and released");
        run_frame(0, 16'h0096, 16'h0069, 1'b0, "post_reset");
    endtask

    task automatic test_wide();
        run_frame(4, 16'hBEEF, 16'h1234, 1'b0, "wide");
        run_frame(4, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0, "wide_rand");
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back();
        test_ignored_start();
        test_modes();
        test_reset_mid();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
